// File: rtl/sr_cmd_gen.sv
// Set/clear command front-end: debounces two raw request inputs and emits mutually exclusive one-cycle s/r pulses.
// Define SR_CMD_SYNC_EN to insert a two-flop synchronizer ahead of each debouncer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a debounced rising edge on set or clear
// PULSE | s or r is high for exactly this cycle
// GAP   | lockout after a pulse; gap_cnt counts down to zero
module sr_cmd_gen #(
    parameter int DB_CYCLES  = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_btn,
    input  logic       clr_btn,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] DB_LAST  = 8'(DB_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

    // bit 0 is the set channel, bit 1 the clear channel
    logic [1:0] btn;
    logic [1:0] samp;
    logic [1:0] rise;

    assign btn = {clr_btn, set_btn};

`ifdef SR_CMD_SYNC_EN
    logic [1:0] sync_q1;
    logic [1:0] sync_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 2'b00;
            sync_q2 <= 2'b00;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    assign samp = sync_q2;
`else
    assign samp = btn;
`endif

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic       lvl;
        logic       lvl_d;
        logic [7:0] cnt;

        // Any sample that agrees with the stable level restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lvl   <= 1'b0;
                lvl_d <= 1'b0;
                cnt   <= 8'd0;
            end else begin
                lvl_d <= lvl;
                if (samp[i] == lvl) begin
                    cnt <= 8'd0;
                end else if (cnt == DB_LAST) begin
                    lvl <= samp[i];
                    cnt <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end

        assign rise[i] = lvl & ~lvl_d;
    end

    state_t     state;
    state_t     state_nxt;
    logic [7:0] gap_cnt;
    logic [7:0] gap_nxt;
    logic       s_nxt;
    logic       r_nxt;
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;
    logic [7:0] drop_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= 8'd0;
            s        <= 1'b0;
            r        <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            gap_cnt  <= gap_nxt;
            s        <= s_nxt;
            r        <= r_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        drop_inc  = 2'd0;
        case (state)
            IDLE: begin
                // Simultaneous requests are ambiguous, so neither wins.
                if (rise == 2'b11) begin
                    drop_inc = 2'd1;
                end else if (rise[0]) begin
                    s_nxt     = 1'b1;
                    state_nxt = PULSE;
                end else if (rise[1]) begin
                    r_nxt     = 1'b1;
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                drop_inc = {1'b0, rise[0]} + {1'b0, rise[1]};
                if (HAS_GAP) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_LAST;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                drop_inc = {1'b0, rise[0]} + {1'b0, rise[1]};
                if (gap_cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};
    assign drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    assign busy = (state != IDLE);

endmodule
